// File: rtl/const_div_seq.sv
// Sequential unsigned divide-by-constant: radix-2^CHUNK digit recurrence, one chunk per clock, MSB first.
// Valid/ready on both sides; a finished result can hand off to the next dividend on the same edge.
module const_div_seq #(
  parameter int WIDTH   = 36,
  parameter int DIVISOR = 113,
  parameter int CHUNK   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_q,
  output logic [$clog2(DIVISOR)-1:0] out_r,
  output logic               busy
);

  localparam int NSTEP = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int RW    = $clog2(DIVISOR);
  localparam int PW    = NSTEP * CHUNK;
  localparam int TW    = RW + CHUNK;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("const_div_seq: DIVISOR %0d outside 2..65535", DIVISOR);
  end
  if (CHUNK < 1 || CHUNK > 8) begin : g_bad_chunk
    $error("const_div_seq: CHUNK %0d outside 1..8", CHUNK);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, stateNext;
  logic [PW-1:0]     xReg;
  logic [WIDTH-1:0]  qReg;
  logic [RW-1:0]     rReg;
  logic [SW-1:0]     step;
  logic [TW-1:0]     partial;
  logic [CHUNK-1:0]  digit;
  logic [RW-1:0]     remNext;
  logic              accept;
  logic              lastStep;

  // One recurrence step; since rReg < DIVISOR the digit always fits in CHUNK bits.
  always_comb begin
    partial  = {rReg, xReg[PW-1 -: CHUNK]};
    digit    = CHUNK'(partial / TW'(DIVISOR));
    remNext  = RW'(partial % TW'(DIVISOR));
    lastStep = (step == SW'(NSTEP - 1));
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state == RUN);
    out_q     = qReg;
    out_r     = rReg;
    accept    = in_valid && in_ready;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = RUN;
      RUN:  if (lastStep) stateNext = DONE;
      DONE: if (out_ready) stateNext = in_valid ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Quotient keeps only WIDTH bits; the dropped top digits are zero by construction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      xReg  <= '0;
      qReg  <= '0;
      rReg  <= '0;
      step  <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        xReg <= PW'(in_x);
        qReg <= '0;
        rReg <= '0;
        step <= '0;
      end else if (state == RUN) begin
        xReg <= xReg << CHUNK;
        qReg <= WIDTH'({qReg, digit});
        rReg <= remNext;
        step <= step + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_const_div_seq.sv
// Directed bench for const_div_seq: default instance plus a small WIDTH=8/DIVISOR=3/CHUNK=3 instance.
module tb_const_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [35:0] in_x;
  logic        in_ready, out_valid, busy;
  logic [35:0] out_q;
  logic [6:0]  out_r;

  logic        sInValid, sOutReady;
  logic [7:0]  sInX;
  logic        sInReady, sOutValid, sBusy;
  logic [7:0]  sOutQ;
  logic [1:0]  sOutR;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  const_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r), .busy(busy)
  );

  const_div_seq #(.WIDTH(8), .DIVISOR(3), .CHUNK(3)) dutSmall (
    .clk(clk), .rst_n(rst_n), .in_valid(sInValid), .in_ready(sInReady), .in_x(sInX),
    .out_valid(sOutValid), .out_ready(sOutReady), .out_q(sOutQ), .out_r(sOutR), .busy(sBusy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offers a dividend in IDLE; returns #1 after the accepting edge with junk on the inputs.
  task automatic applyStimulus(input logic [35:0] x);
    in_valid = 1'b1;
    in_x     = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x     = 36'({$urandom(), $urandom()});
  endtask

  // Waits for out_valid while wiggling in_valid/in_x, then checks latency and result.
  task automatic checkOutput(input string tag, input logic [35:0] expQ, input logic [6:0] expR);
    int n = 1;
    while (!out_valid && n < 40) begin
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      check({tag, "_inready"}, {63'd0, in_ready}, 64'd0);
      in_valid = 1'($urandom_range(0, 1));
      in_x     = 36'({$urandom(), $urandom()});
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd10);
    check({tag, "_q"}, 64'(out_q), 64'(expQ));
    check({tag, "_r"}, 64'(out_r), 64'(expR));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  logic [7:0] smallX [2]  = '{8'd255, 8'd200};
  logic [7:0] smallQ [2]  = '{8'd85, 8'd66};
  logic [1:0] smallR [2]  = '{2'd0, 2'd2};

  initial begin
    logic seenValid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0;
    sInValid = 1'b0; sOutReady = 1'b0; sInX = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inready", {63'd0, in_ready}, 64'd1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_q", 64'(out_q), 64'd0);
    check("rst_r", 64'(out_r), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(36'd112);        checkOutput("x112", 36'd0, 7'd112);    consume("x112");
    applyStimulus(36'd113);        checkOutput("x113", 36'd1, 7'd0);      consume("x113");
    applyStimulus(36'd0);          checkOutput("x0", 36'd0, 7'd0);        consume("x0");
    applyStimulus(36'd1000000);    checkOutput("x1e6", 36'd8849, 7'd63);  consume("x1e6");
    applyStimulus(36'd34359738368); checkOutput("x2p35", 36'd304068481, 7'd15); consume("x2p35");

    // Stall in DONE, then hand off to the next dividend on the same edge.
    applyStimulus(36'hF_FFFF_FFFF);
    checkOutput("allones", 36'd608136962, 7'd29);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x     = 36'd999;
      @(posedge clk); #1;
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_q", 64'(out_q), 64'd608136962);
      check("stall_r", 64'(out_r), 64'd29);
      check("stall_inready", {63'd0, in_ready}, 64'd0);
    end
    in_x      = 36'd226;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("handoff_busy", {63'd0, busy}, 64'd1);
    check("handoff_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("x226", 36'd2, 7'd0);
    consume("x226");

    // Reset pulse at step 4 discards the operation.
    applyStimulus(36'd1000000);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_inready", {63'd0, in_ready}, 64'd1);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_q", 64'(out_q), 64'd0);
    check("midrst_r", 64'(out_r), 64'd0);
    seenValid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seenValid |= out_valid;
    end
    check("midrst_novalid", {63'd0, seenValid}, 64'd0);
    applyStimulus(36'd500);  checkOutput("x500", 36'd4, 7'd48);  consume("x500");

    // Small instance: NSTEP=3, dividend zero-extended to 9 bits.
    for (int k = 0; k < 2; k++) begin
      int n;
      sInValid = 1'b1;
      sInX     = smallX[k];
      @(posedge clk); #1;
      sInValid = 1'b0;
      sInX     = 8'h5A;
      n = 1;
      while (!sOutValid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("small_latency", 64'(n), 64'd4);
      check("small_q", 64'(sOutQ), 64'(smallQ[k]));
      check("small_r", 64'(sOutR), 64'(smallR[k]));
      sOutReady = 1'b1;
      @(posedge clk); #1;
      sOutReady = 1'b0;
      check("small_drained", {63'd0, sOutValid}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
